hb_boot_sequencer: RTL and testbench
====================================

Name: hb_boot_sequencer

Overview:
- Harvard-bus initiator that drives the boot/download controller's register window from the bus-master side.
- After reset it probes the download-mode bit and streams the ROM banner string byte-by-byte to a byte sink (UART TX) over valid/ready.
- If download mode is requested, it hands off to the download engine and waits for completion.
- It then writes the run key to the debug register, switching the core from boot to user code.

Parameters:
- BASE_ADDR, 32'h0, word base of the boot controller register window on the bus.
- STR_START, 6'd0, ROM string start index written to the string-address register.
- MAX_LEN, 64, maximum banner bytes fetched (1..64); guards against a missing NUL terminator.
- RUN_KEY, 8'hF0, value written to the debug register to enter user mode.
- TIMEOUT_CYC, 1024, tx_ready stall limit; used only with the optional feature.

Ports:
- hb_clk  in  1  bus clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that starts the sequence; ignored unless in IDLE.
- hb_ren  out  1  bus read strobe; exactly one-cycle pulse per read.
- hb_raddr  out  32  read address = BASE_ADDR + offset.
- hb_wen  out  1  bus write strobe; one-cycle pulse.
- hb_waddr  out  32  write address = BASE_ADDR + offset.
- hb_wdata  out  32  write data.
- hb_rdata  in  32  slave read data, registered; valid the cycle after hb_ren, zero otherwise.
- tx_data  out  8  banner byte.
- tx_valid  out  1  banner byte valid.
- tx_ready  in  1  sink accepts the byte.
- dl_req  out  1  download engine request; level signal.
- dl_done  in  1  download engine finished; pulse or level.
- busy  out  1  sequence in progress.
- done  out  1  run key written; sticky until the next start.
- aborted  out  1  banner abandoned on timeout; only with the optional feature, otherwise tied 0.

Behaviour:
- Register offsets (word index):
  - 0 DEBUG: read bit0 = download_mode; write = run-mode byte.
  - 1 STR_ADDR: write-only, low 6 bits.
  - 2 STR_DATA: read returns the byte at the ROM pointer, then post-increments the pointer.
- Reset values: all outputs 0; state IDLE; byte counter 0.
- FSM states and transitions:
  - IDLE: on start go to PROBE; busy=1 and done=0 from the next cycle.
  - PROBE: pulse hb_ren for 1 cycle, hb_raddr=BASE+0, then go to PROBE_W.
  - PROBE_W: latch dl_mode=hb_rdata[0], then go to SETPTR.
  - SETPTR: pulse hb_wen, waddr=BASE+1, wdata={26'b0,STR_START}; clear the counter; go to STR_RD.
  - STR_RD: pulse hb_ren, raddr=BASE+2, then go to STR_W.
  - STR_W: capture hb_rdata[7:0] into tx_data and increment the counter.
    - Byte==0: go to HANDOFF; the NUL is not emitted.
    - Otherwise: assert tx_valid and go to EMIT.
  - EMIT: hold tx_valid and tx_data stable until tx_valid&&tx_ready.
    - On acceptance, drop tx_valid the same edge.
    - Counter==MAX_LEN: go to HANDOFF.
    - Otherwise: go to STR_RD.
  - HANDOFF:
    - dl_mode=0: go to KEY.
    - dl_mode=1: assert dl_req, hold it until dl_done is sampled 1, deassert, then go to KEY.
  - KEY: pulse hb_wen, waddr=BASE+0, wdata={24'b0,RUN_KEY}, then go to DONE.
  - DONE: busy=0, done=1; a later start restarts from PROBE.
- Bus rules:
  - Never assert hb_ren and hb_wen in the same cycle.
  - Never issue a new STR_DATA read before the previous data is consumed; each extra ren advances the ROM pointer, so ren must be a single-cycle pulse.
- Latency: with tx_ready tied 1, each banner byte costs 3 cycles (STR_RD, STR_W, EMIT).
- Boundary conditions:
  - MAX_LEN=64 with no NUL: exactly 64 bytes are emitted; the pointer wrap to 0 in the slave is irrelevant.
  - dl_done already high on entering HANDOFF: dl_req is asserted for 1 cycle, then the FSM proceeds.
  - start while busy: ignored.
  - rst_n low mid-sequence: immediate return to IDLE, all strobes 0 asynchronously; no partial write is issued afterwards.
  - The slave resets its run mode on its own reset; this block does not re-run automatically.

Optional Feature:
- Macro HB_BOOT_TX_TIMEOUT_EN.
- Defined: a stall counter runs in EMIT while tx_valid&&!tx_ready and resets when a byte is accepted or EMIT is left.
  - Counter reaches TIMEOUT_CYC-1: drop tx_valid, set aborted (sticky until the next start), go directly to HANDOFF.
- Undefined: EMIT waits indefinitely; aborted is tied 0; no counter logic.

Decomposition:
- Package boot_pkg: register offset localparams (DEBUG=0, STR_ADDR=1, STR_DATA=2), default RUN_KEY, and the FSM state enum typedef.
- Bus field widths come from XT_BUS.
- One sub-module, boot_stall_timer (counter with clear, enable and expire), instantiated only under HB_BOOT_TX_TIMEOUT_EN.

Test Plan:
- Slave model: ROM "Hi\0", download_mode=0, tx_ready=1, start pulse -> write to BASE+1 with 0, reads of BASE+2 x3, tx bytes 0x48 then 0x69, write BASE+0 = 0xF0, done=1 with no dl_req.
- download_mode=1, dl_done raised 20 cycles after dl_req -> dl_req held exactly until dl_done, then the single 0xF0 write.
- ROM of 64 non-zero bytes, MAX_LEN=64 -> exactly 64 tx handshakes and 64 STR_DATA reads, then the key write.
- tx_ready toggling 1/0 each cycle -> tx_data stable while valid and unaccepted; byte order intact; each ren is a 1-cycle pulse.
- rst_n asserted during EMIT -> all outputs 0 immediately; after release and a new start, the sequence restarts from PROBE.
- HB_BOOT_TX_TIMEOUT_EN defined, TIMEOUT_CYC=8, tx_ready=0 -> tx_valid drops after 8 stalled cycles, aborted=1, 0xF0 is still written.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the Harvard-bus boot sequencer.
// Register window offsets, bus widths and the sequencer state encoding.
package boot_pkg;

    localparam int XT_BUS_AW = 32;
    localparam int XT_BUS_DW = 32;
    localparam int TX_DW     = 8;
    localparam int STR_AW    = 6;
    localparam int CNT_W     = 7;

    localparam logic [XT_BUS_AW-1:0] OFF_DEBUG    = 32'd0;
    localparam logic [XT_BUS_AW-1:0] OFF_STR_ADDR = 32'd1;
    localparam logic [XT_BUS_AW-1:0] OFF_STR_DATA = 32'd2;

    localparam logic [TX_DW-1:0] RUN_KEY_DEF = 8'hF0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PROBE,
        S_PROBE_W,
        S_SETPTR,
        S_STR_RD,
        S_STR_W,
        S_EMIT,
        S_HANDOFF,
        S_KEY,
        S_DONE
    } boot_state_t;

    function automatic logic [XT_BUS_AW-1:0] reg_addr(
        input logic [XT_BUS_AW-1:0] base,
        input logic [XT_BUS_AW-1:0] off
    );
        return base + off;
    endfunction

endpackage

// File: rtl/boot_stall_timer.sv
// Stall counter with clear/enable; expires on the LIMIT-th enabled cycle.
// Used by hb_boot_sequencer only when HB_BOOT_TX_TIMEOUT_EN is defined.
module boot_stall_timer #(
    parameter int LIMIT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/hb_boot_sequencer.sv
// Boot sequencer: probes download mode, streams the ROM banner, writes run key.
// Optional tx_ready stall timeout is enabled by defining HB_BOOT_TX_TIMEOUT_EN.
module hb_boot_sequencer
    import boot_pkg::*;
#(
    parameter logic [XT_BUS_AW-1:0] BASE_ADDR   = 32'h0,
    parameter logic [STR_AW-1:0]    STR_START   = 6'd0,
    parameter int                   MAX_LEN     = 64,
    parameter logic [TX_DW-1:0]     RUN_KEY     = RUN_KEY_DEF,
    parameter int                   TIMEOUT_CYC = 1024
) (
    input  logic                 hb_clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 hb_ren,
    output logic [XT_BUS_AW-1:0] hb_raddr,
    output logic                 hb_wen,
    output logic [XT_BUS_AW-1:0] hb_waddr,
    output logic [XT_BUS_DW-1:0] hb_wdata,
    input  logic [XT_BUS_DW-1:0] hb_rdata,
    output logic [TX_DW-1:0]     tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 dl_req,
    input  logic                 dl_done,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 64 || TIMEOUT_CYC < 2) begin : g_cfg_err
        $error("hb_boot_sequencer: parameter out of range");
    end

    boot_state_t        r_state;
    boot_state_t        w_state_nxt;
    logic               r_dl_mode;
    logic [TX_DW-1:0]   r_tx_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_expire;
    logic               w_start_ok;
    logic [XT_BUS_DW-9:0] w_unused_rdata;

    assign w_unused_rdata = hb_rdata[XT_BUS_DW-1:8];
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef HB_BOOT_TX_TIMEOUT_EN
    logic w_stall;
    logic r_aborted;

    assign w_stall = (r_state == S_EMIT) && !tx_ready;

    // Clearing whenever not stalled covers both acceptance and leaving EMIT.
    boot_stall_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_stall (
        .i_clk    (hb_clk),
        .i_rst_n  (rst_n),
        .i_clr    (!w_stall),
        .i_en     (w_stall),
        .o_expire (w_expire)
    );

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else if (w_start_ok) begin
            r_aborted <= 1'b0;
        end else if (w_expire) begin
            r_aborted <= 1'b1;
        end
    end

    assign aborted = r_aborted;
`else
    assign w_expire = 1'b0;
    assign aborted  = 1'b0;
`endif

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hb_ren      = 1'b0;
        hb_raddr    = '0;
        hb_wen      = 1'b0;
        hb_waddr    = '0;
        hb_wdata    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PROBE;
            end
            S_PROBE: begin
                hb_ren      = 1'b1;
                hb_raddr    = reg_addr(BASE_ADDR, OFF_DEBUG);
                w_state_nxt = S_PROBE_W;
            end
            S_PROBE_W: begin
                w_state_nxt = S_SETPTR;
            end
            S_SETPTR: begin
                hb_wen      = 1'b1;
                hb_waddr    = reg_addr(BASE_ADDR, OFF_STR_ADDR);
                hb_wdata    = {26'b0, STR_START};
                w_state_nxt = S_STR_RD;
            end
            S_STR_RD: begin
                hb_ren      = 1'b1;
                hb_raddr    = reg_addr(BASE_ADDR, OFF_STR_DATA);
                w_state_nxt = S_STR_W;
            end
            S_STR_W: begin
                if (hb_rdata[7:0] == 8'h00) w_state_nxt = S_HANDOFF;
                else                        w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (tx_ready) begin
                    if (r_cnt == LP_MAX) w_state_nxt = S_HANDOFF;
                    else                 w_state_nxt = S_STR_RD;
                end else if (w_expire) begin
                    w_state_nxt = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                if (!r_dl_mode || dl_done) w_state_nxt = S_KEY;
            end
            S_KEY: begin
                hb_wen      = 1'b1;
                hb_waddr    = reg_addr(BASE_ADDR, OFF_DEBUG);
                hb_wdata    = {24'b0, RUN_KEY};
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_PROBE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_mode <= 1'b0;
            r_tx_data <= '0;
            r_cnt     <= '0;
        end else begin
            if (r_state == S_PROBE_W) r_dl_mode <= hb_rdata[0];
            if (r_state == S_SETPTR)  r_cnt     <= '0;
            if (r_state == S_STR_W) begin
                r_tx_data <= hb_rdata[7:0];
                r_cnt     <= r_cnt + 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = (r_state == S_EMIT);
    assign dl_req   = (r_state == S_HANDOFF) && r_dl_mode;
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_hb_boot_sequencer.sv
// Bench for hb_boot_sequencer: register-window slave model, byte scoreboard.
// Define HB_BOOT_TX_TIMEOUT_EN to also exercise the tx_ready stall timeout.
module tb_hb_boot_sequencer;

    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam int          TO   = 8;

    logic        hb_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        hb_ren;
    logic [31:0] hb_raddr;
    logic        hb_wen;
    logic [31:0] hb_waddr;
    logic [31:0] hb_wdata;
    logic [31:0] hb_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        dl_req;
    logic        dl_done  = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  rom [64];
    logic [5:0]  ptr = '0;
    logic        dl_mode = 1'b0;

    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [63:0] wlog  [$];
    int str_reads, probe_reads, dl_req_cycles, valid_cycles;
    int viol_both, viol_ren, viol_stable, viol_wen_dl;
    logic prev_ren, prev_hold;
    logic [7:0] prev_data;

    always #5 hb_clk = ~hb_clk;

    hb_boot_sequencer #(
        .BASE_ADDR   (BASE),
        .STR_START   (6'd0),
        .MAX_LEN     (64),
        .RUN_KEY     (8'hF0),
        .TIMEOUT_CYC (TO)
    ) dut (
        .hb_clk   (hb_clk),
        .rst_n    (rst_n),
        .start    (start),
        .hb_ren   (hb_ren),
        .hb_raddr (hb_raddr),
        .hb_wen   (hb_wen),
        .hb_waddr (hb_waddr),
        .hb_wdata (hb_wdata),
        .hb_rdata (hb_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .dl_req   (dl_req),
        .dl_done  (dl_done),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    // Register-window slave: registered read data, zero when not reading.
    always @(posedge hb_clk) begin
        hb_rdata <= '0;
        if (hb_ren && hb_raddr == BASE)
            hb_rdata <= {31'b0, dl_mode};
        if (hb_ren && hb_raddr == BASE + 2) begin
            hb_rdata <= {24'b0, rom[ptr]};
            ptr <= ptr + 1'b1;
        end
        if (hb_wen && hb_waddr == BASE + 1)
            ptr <= hb_wdata[5:0];
    end

    // Bus/stream monitor.
    always @(negedge hb_clk) begin
        if (!rst_n) begin
            prev_ren  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (hb_ren && hb_wen) viol_both++;
            if (hb_ren && prev_ren) viol_ren++;
            if (hb_wen && dl_req) viol_wen_dl++;
            if (hb_ren && hb_raddr == BASE + 2) str_reads++;
            if (hb_ren && hb_raddr == BASE) probe_reads++;
            if (hb_wen) wlog.push_back({hb_waddr, hb_wdata});
            if (prev_hold && tx_valid && tx_data !== prev_data) viol_stable++;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (tx_valid) valid_cycles++;
            if (dl_req) dl_req_cycles++;
            prev_ren  = hb_ren;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        wlog.delete();
        str_reads = 0; probe_reads = 0; dl_req_cycles = 0; valid_cycles = 0;
        viol_both = 0; viol_ren = 0; viol_stable = 0; viol_wen_dl = 0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) begin
            rom[i] = s[i];
            exp_q.push_back(s[i]);
        end
    endtask

    task automatic pulse_start();
        @(posedge hb_clk); #1 start = 1'b1;
        @(posedge hb_clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hb_clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({busy, done, aborted} !== 3'b000)
            $display("FAIL reset_status got=%b exp=000", {busy, done, aborted});
        else n_pass++;
        n_total++;
        if ({hb_ren, hb_wen, tx_valid, dl_req} !== 4'b0000)
            $display("FAIL reset_strobes got=%b exp=0000", {hb_ren, hb_wen, tx_valid, dl_req});
        else n_pass++;
        n_total++;
        if ({hb_raddr, hb_waddr, hb_wdata, tx_data} !== 104'd0)
            $display("FAIL reset_buses got=%h exp=0", {hb_raddr, hb_waddr, hb_wdata, tx_data});
        else n_pass++;
        @(posedge hb_clk); #1 rst_n = 1'b1;
        clear_logs();
        repeat (4) @(posedge hb_clk);
        #1;
        n_total++;
        if (busy !== 1'b0 || probe_reads !== 0)
            $display("FAIL idle_no_start got busy=%0b reads=%0d exp 0/0", busy, probe_reads);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] e, g;
        clear_logs();
        dl_mode = 1'b0; tx_ready = 1'b1;
        load_str("Hi");
        pulse_start();
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL basic_busy got busy=%0b done=%0b exp 1/0", busy, done);
        else n_pass++;
        repeat (2) @(posedge hb_clk);
        #1 start = 1'b1;
        @(posedge hb_clk); #1 start = 1'b0;
        wait_done(200, ok);
        n_total++;
        if (!ok) $display("FAIL basic_done got=0 exp=1 within budget");
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_total++;
            if (g !== e) $display("FAIL basic_byte got=%h exp=%h", g, e);
            else n_pass++;
        end
        n_total++;
        if (got_q.size() != 0 || str_reads != 3 || probe_reads != 1)
            $display("FAIL basic_counts got extra=%0d reads=%0d probes=%0d exp 0/3/1",
                     got_q.size(), str_reads, probe_reads);
        else n_pass++;
        n_total++;
        if (wlog.size() != 2)
            $display("FAIL basic_wcount got=%0d exp=2", wlog.size());
        else n_pass++;
        if (wlog.size() == 2) begin
            n_total++;
            if (wlog[0] !== {BASE + 32'd1, 32'd0})
                $display("FAIL basic_setptr got=%h exp=%h", wlog[0], {BASE + 32'd1, 32'd0});
            else n_pass++;
            n_total++;
            if (wlog[1] !== {BASE, 32'h0000_00F0})
                $display("FAIL basic_key got=%h exp=%h", wlog[1], {BASE, 32'h0000_00F0});
            else n_pass++;
        end
        n_total++;
        if (dl_req_cycles != 0 || busy !== 1'b0 || aborted !== 1'b0)
            $display("FAIL basic_final got dlreq=%0d busy=%0b ab=%0b exp 0/0/0",
                     dl_req_cycles, busy, aborted);
        else n_pass++;
    endtask

    task automatic test_download();
        bit ok;
        bit seen;
        clear_logs();
        dl_mode = 1'b1; tx_ready = 1'b1; dl_done = 1'b0;
        load_str("A");
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge hb_clk);
            if (dl_req) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!seen) $display("FAIL dl_req_seen got=0 exp=1");
        else n_pass++;
        repeat (20) @(posedge hb_clk);
        #1 dl_done = 1'b1;
        @(posedge hb_clk); #1 dl_done = 1'b0;
        wait_done(100, ok);
        n_total++;
        if (!ok || dl_req_cycles != 21)
            $display("FAIL dl_hold got done=%0b cycles=%0d exp 1/21", ok, dl_req_cycles);
        else n_pass++;
        n_total++;
        if (wlog.size() != 2 || wlog[wlog.size()-1] !== {BASE, 32'h0000_00F0} || viol_wen_dl != 0)
            $display("FAIL dl_key got n=%0d last=%h ov=%0d exp 2/%h/0",
                     wlog.size(), wlog[wlog.size()-1], viol_wen_dl, {BASE, 32'h0000_00F0});
        else n_pass++;
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0])
            $display("FAIL dl_byte got n=%0d b=%h exp 1/%h", got_q.size(), got_q[0], exp_q[0]);
        else n_pass++;
    endtask

    task automatic test_dl_done_early();
        bit ok;
        clear_logs();
        dl_mode = 1'b1; tx_ready = 1'b1; dl_done = 1'b1;
        load_str("");
        pulse_start();
        wait_done(100, ok);
        dl_done = 1'b0;
        n_total++;
        if (!ok || dl_req_cycles != 1)
            $display("FAIL dl_early got done=%0b cycles=%0d exp 1/1", ok, dl_req_cycles);
        else n_pass++;
        n_total++;
        if (got_q.size() != 0 || str_reads != 1 || wlog.size() != 2)
            $display("FAIL dl_early_bus got tx=%0d reads=%0d w=%0d exp 0/1/2",
                     got_q.size(), str_reads, wlog.size());
        else n_pass++;
    endtask

    task automatic test_max_len();
        bit ok;
        logic [7:0] e, g;
        int bad;
        clear_logs();
        dl_mode = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 8'h20 + 8'(i);
            exp_q.push_back(8'h20 + 8'(i));
        end
        pulse_start();
        wait_done(1000, ok);
        n_total++;
        if (!ok || got_q.size() != 64 || str_reads != 64)
            $display("FAIL maxlen_counts got done=%0b tx=%0d reads=%0d exp 1/64/64",
                     ok, got_q.size(), str_reads);
        else n_pass++;
        bad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (g !== e) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL maxlen_bytes got=%0d wrong exp=0", bad);
        else n_pass++;
        n_total++;
        if (wlog.size() != 2 || wlog[1] !== {BASE, 32'h0000_00F0})
            $display("FAIL maxlen_key got n=%0d last=%h exp 2/%h",
                     wlog.size(), wlog[wlog.size()-1], {BASE, 32'h0000_00F0});
        else n_pass++;
    endtask

    task automatic test_toggle();
        logic [7:0] e, g;
        clear_logs();
        dl_mode = 1'b0; tx_ready = 1'b1;
        load_str("OK!");
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(posedge hb_clk);
            #1 tx_ready = ~tx_ready;
            if (done) break;
        end
        tx_ready = 1'b1;
        n_total++;
        if (done !== 1'b1) $display("FAIL toggle_done got=%0b exp=1", done);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_total++;
            if (g !== e) $display("FAIL toggle_byte got=%h exp=%h", g, e);
            else n_pass++;
        end
        n_total++;
        if (viol_stable != 0 || viol_ren != 0 || viol_both != 0 || str_reads != 4)
            $display("FAIL toggle_bus got stab=%0d ren=%0d both=%0d reads=%0d exp 0/0/0/4",
                     viol_stable, viol_ren, viol_both, str_reads);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        logic [7:0] e, g;
        clear_logs();
        dl_mode = 1'b0; tx_ready = 1'b0;
        load_str("Hello");
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge hb_clk);
            if (tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++;
        if (!seen) $display("FAIL rstmid_emit got=0 exp=1");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, hb_ren, hb_wen, tx_valid, dl_req, tx_data} !== 14'd0)
            $display("FAIL rstmid_async got=%b exp=0",
                     {busy, done, hb_ren, hb_wen, tx_valid, dl_req, tx_data});
        else n_pass++;
        @(posedge hb_clk); #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        clear_logs();
        repeat (5) @(posedge hb_clk);
        #1;
        n_total++;
        if (wlog.size() != 0 || probe_reads != 0 || busy !== 1'b0)
            $display("FAIL rstmid_quiet got w=%0d r=%0d busy=%0b exp 0/0/0",
                     wlog.size(), probe_reads, busy);
        else n_pass++;
        load_str("Hi");
        pulse_start();
        wait_done(200, ok);
        n_total++;
        if (!ok || probe_reads != 1 || wlog.size() != 2 || wlog[0] !== {BASE + 32'd1, 32'd0})
            $display("FAIL rstmid_restart got done=%0b probes=%0d w=%0d exp 1/1/2",
                     ok, probe_reads, wlog.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_total++;
            if (g !== e) $display("FAIL rstmid_byte got=%h exp=%h", g, e);
            else n_pass++;
        end
    endtask

`ifdef HB_BOOT_TX_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_logs();
        dl_mode = 1'b0; tx_ready = 1'b0;
        load_str("Hi");
        pulse_start();
        wait_done(200, ok);
        n_total++;
        if (!ok || valid_cycles != TO || got_q.size() != 0)
            $display("FAIL timeout_valid got done=%0b vcyc=%0d tx=%0d exp 1/%0d/0",
                     ok, valid_cycles, got_q.size(), TO);
        else n_pass++;
        n_total++;
        if (aborted !== 1'b1 || wlog.size() != 2 || wlog[1] !== {BASE, 32'h0000_00F0})
            $display("FAIL timeout_key got ab=%0b w=%0d exp 1/2", aborted, wlog.size());
        else n_pass++;
        tx_ready = 1'b1;
        clear_logs();
        load_str("Hi");
        pulse_start();
        n_total++;
        if (aborted !== 1'b0) $display("FAIL timeout_clear got=%0b exp=0", aborted);
        else n_pass++;
        wait_done(200, ok);
        n_total++;
        if (!ok || aborted !== 1'b0 || got_q.size() != 2)
            $display("FAIL timeout_rerun got done=%0b ab=%0b tx=%0d exp 1/0/2",
                     ok, aborted, got_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        clear_logs();
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        test_reset();
        test_basic();
        test_download();
        test_dl_done_early();
        test_max_len();
        test_toggle();
        test_reset_mid();
`ifdef HB_BOOT_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
